// File: rtl/piezo_keyboard_seq.sv
// ============================================================================
// piezo_keyboard_seq
// ----------------------------------------------------------------------------
// Turns a vector of key inputs into one square-wave piezo drive. Only the
// lowest-index pressed key sounds. A note's divisor comes from DIV_TABLE,
// right-shifted by the octave input when the note is loaded. After the last
// key is released the tone sustains for SUSTAIN_CYCLES clocks.
//
// Optional feature macro: PIEZO_DEBOUNCE_EN
//   defined   -> each synchronised key passes a DEB_CYCLES stability filter
//   undefined -> synchronised keys feed the priority select directly
//
// Ports:
//   clk_i      system clock
//   rst_ni     asynchronous active-low reset
//   enable_i   global play enable; low forces IDLE on the next edge
//   button_i   raw active-high keys, asynchronous to clk_i
//   octave_i   divisor right-shift (0..3), sampled only when a note loads
//   piezo_o    registered square-wave drive
//   active_o   high whenever the sequencer is not IDLE
//   key_idx_o  index of the currently loaded note (held while IDLE)
// ============================================================================
module piezo_keyboard_seq #(
    parameter int NUM_KEYS       = 8,
    parameter int CNT_W          = 12,
    parameter logic [NUM_KEYS*CNT_W-1:0] DIV_TABLE =
        {12'd1911, 12'd2025, 12'd2273, 12'd2551,
         12'd2863, 12'd3034, 12'd3405, 12'd3822},
    parameter int SUSTAIN_CYCLES = 1000,
    parameter int DEB_CYCLES     = 16,
    localparam int IDX_W         = $clog2(NUM_KEYS)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                enable_i,
    input  logic [NUM_KEYS-1:0] button_i,
    input  logic [1:0]          octave_i,
    output logic                piezo_o,
    output logic                active_o,
    output logic [IDX_W-1:0]    key_idx_o
);

    localparam int SUS_W = (SUSTAIN_CYCLES > 1) ? $clog2(SUSTAIN_CYCLES) : 1;
    localparam logic [SUS_W-1:0] SUS_LAST =
        SUS_W'((SUSTAIN_CYCLES > 0) ? (SUSTAIN_CYCLES - 1) : 0);
    localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        SUSTAIN = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Two-flop synchroniser for the asynchronous key inputs
    // ------------------------------------------------------------------
    logic [NUM_KEYS-1:0] sync1_q;
    logic [NUM_KEYS-1:0] btn_s_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            btn_s_q <= '0;
        end else begin
            sync1_q <= button_i;
            btn_s_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Key source for selection (optionally debounced)
    // ------------------------------------------------------------------
    logic [NUM_KEYS-1:0] btn_src;

`ifdef PIEZO_DEBOUNCE_EN
    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST =
        DEB_W'((DEB_CYCLES > 0) ? (DEB_CYCLES - 1) : 0);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_deb
            logic [DEB_W-1:0] deb_cnt_q;
            logic             deb_bit_q;

            // The filtered bit only follows btn_s after it has disagreed for
            // DEB_CYCLES consecutive cycles; any agreement restarts the count.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    deb_cnt_q <= '0;
                    deb_bit_q <= 1'b0;
                end else if (btn_s_q[gi] != deb_bit_q) begin
                    if (deb_cnt_q == DEB_LAST) begin
                        deb_bit_q <= btn_s_q[gi];
                        deb_cnt_q <= '0;
                    end else begin
                        deb_cnt_q <= deb_cnt_q + 1'b1;
                    end
                end else begin
                    deb_cnt_q <= '0;
                end
            end

            assign btn_src[gi] = deb_bit_q;
        end
    endgenerate
`else
    assign btn_src = btn_s_q;
`endif

    // ------------------------------------------------------------------
    // Priority select: lowest set bit wins, registered every cycle
    // ------------------------------------------------------------------
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic             sel_valid_q;
    logic [IDX_W-1:0] sel_idx_q;

    always_comb begin
        pick_valid = |btn_src;
        pick_idx   = '0;
        // Scan downwards so the lowest set index is the last one written.
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (btn_src[k]) begin
                pick_idx = IDX_W'(k);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sel_valid_q <= 1'b0;
            sel_idx_q   <= '0;
        end else begin
            sel_valid_q <= pick_valid;
            sel_idx_q   <= pick_idx;
        end
    end

    // ------------------------------------------------------------------
    // Divisor lookup with octave shift and a floor of 2 so the waveform
    // always has at least one high and one low cycle.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] div_tab [NUM_KEYS];
    logic [CNT_W-1:0] div_shift;
    logic [CNT_W-1:0] div_load;

    genvar ti;
    generate
        for (ti = 0; ti < NUM_KEYS; ti++) begin : g_tab
            assign div_tab[ti] = DIV_TABLE[ti*CNT_W +: CNT_W];
        end
    endgenerate

    always_comb begin
        div_shift = div_tab[sel_idx_q] >> octave_i;
        div_load  = (div_shift < MIN_DIV) ? MIN_DIV : div_shift;
    end

    // ------------------------------------------------------------------
    // Sequencer FSM and tone generator
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [IDX_W-1:0] key_idx_q, key_idx_d;
    logic [CNT_W-1:0] d_eff_q, d_eff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUS_W-1:0] sus_q, sus_d;
    logic             piezo_q, piezo_d;

    logic             tone_hi;
    logic [CNT_W-1:0] cnt_adv;
    logic             load;

    always_comb begin
        tone_hi = (cnt_q < (d_eff_q >> 1));
        cnt_adv = (cnt_q == (d_eff_q - 1'b1)) ? '0 : (cnt_q + 1'b1);
    end

    always_comb begin
        state_d   = state_q;
        key_idx_d = key_idx_q;
        d_eff_d   = d_eff_q;
        cnt_d     = cnt_q;
        sus_d     = sus_q;
        piezo_d   = 1'b0;
        load      = 1'b0;

        if (!enable_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (sel_valid_q) begin
                        state_d = PLAY;
                        load    = 1'b1;
                    end
                end
                PLAY: begin
                    if (!sel_valid_q) begin
                        if (SUSTAIN_CYCLES == 0) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = SUSTAIN;
                            sus_d   = '0;
                            piezo_d = tone_hi;
                            cnt_d   = cnt_adv;
                        end
                    end else if (sel_idx_q != key_idx_q) begin
                        load = 1'b1;
                    end else begin
                        piezo_d = tone_hi;
                        cnt_d   = cnt_adv;
                    end
                end
                SUSTAIN: begin
                    if (sel_valid_q) begin
                        // Any key during sustain restarts the note, even the same one.
                        state_d = PLAY;
                        load    = 1'b1;
                    end else if (sus_q == SUS_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        sus_d   = sus_q + 1'b1;
                        piezo_d = tone_hi;
                        cnt_d   = cnt_adv;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // A load restarts the waveform at cnt=0; the output rests low for
        // that one edge and the new period begins high on the next.
        if (load) begin
            key_idx_d = sel_idx_q;
            d_eff_d   = div_load;
            cnt_d     = '0;
            piezo_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            key_idx_q <= '0;
            d_eff_q   <= MIN_DIV;
            cnt_q     <= '0;
            sus_q     <= '0;
            piezo_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            key_idx_q <= key_idx_d;
            d_eff_q   <= d_eff_d;
            cnt_q     <= cnt_d;
            sus_q     <= sus_d;
            piezo_q   <= piezo_d;
        end
    end

    assign piezo_o   = piezo_q;
    assign active_o  = (state_q != IDLE);
    assign key_idx_o = key_idx_q;

endmodule

// File: tb/tb_piezo_keyboard_seq.sv
// Bench for piezo_keyboard_seq: directed phases followed by random key/octave/
// enable traffic, every cycle compared against a time-based reference model.
module tb_piezo_keyboard_seq;

    localparam int NK  = 8;
    localparam int CW  = 12;
    localparam int SUS = 20;
    localparam logic [NK*CW-1:0] TAB = {12'd10, 12'd10, 12'd10, 12'd10,
                                        12'd10, 12'd10, 12'd6,  12'd8};

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          en     = 1'b0;
    logic [NK-1:0] btn    = '0;
    logic [1:0]    oct    = 2'd0;
    logic          piezo;
    logic          active;
    logic [2:0]    kidx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    piezo_keyboard_seq #(
        .NUM_KEYS      (NK),
        .CNT_W         (CW),
        .DIV_TABLE     (TAB),
        .SUSTAIN_CYCLES(SUS),
        .DEB_CYCLES    (4)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .enable_i (en),
        .button_i (btn),
        .octave_i (oct),
        .piezo_o  (piezo),
        .active_o (active),
        .key_idx_o(kidx)
    );

    // ---------------- reference model ----------------
    // Keys reach the sequencer three edges after they are sampled; the tone is
    // described by the number of edges elapsed since the note was loaded.
    logic [NK-1:0] hist [3];
    int  m_state;   // 0 idle, 1 play, 2 sustain
    int  m_key;
    int  m_div;
    int  m_t;
    int  m_sus;
    bit  exp_p;

    function automatic int note_div(int k, int o);
        int d;
        d = (k == 0) ? 8 : ((k == 1) ? 6 : 10);
        d = d >> o;
        return (d < 2) ? 2 : d;
    endfunction

    function automatic int lowest(logic [NK-1:0] v);
        for (int i = 0; i < NK; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) hist[i] = '0;
        m_state = 0; m_key = 0; m_div = 2; m_t = 0; m_sus = 0; exp_p = 1'b0;
    endtask

    task automatic model_load(logic [NK-1:0] v);
        m_key = lowest(v); m_div = note_div(m_key, int'(oct));
        m_t = 0; m_state = 1; exp_p = 1'b0;
    endtask

    task automatic model_tone();
        exp_p = ((m_t % m_div) < (m_div / 2));
        m_t++;
    endtask

    task automatic model_edge();
        logic [NK-1:0] v;
        v = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = btn;
        if (!en) begin
            m_state = 0; exp_p = 1'b0;
        end else if (m_state == 0) begin
            exp_p = 1'b0;
            if (v != '0) model_load(v);
        end else if (m_state == 1) begin
            if (v == '0) begin
                if (SUS == 0) begin m_state = 0; exp_p = 1'b0; end
                else begin m_state = 2; m_sus = 0; model_tone(); end
            end else if (lowest(v) != m_key) model_load(v);
            else model_tone();
        end else begin
            if (v != '0) model_load(v);
            else if (m_sus == SUS - 1) begin m_state = 0; exp_p = 1'b0; end
            else begin m_sus++; model_tone(); end
        end
    endtask

    task automatic check_outputs(string tag);
        checks++;
        assert (piezo === exp_p) else begin
            errors++; $error("FAIL %s piezo: got %b expected %b", tag, piezo, exp_p);
        end
        checks++;
        assert (active === (m_state != 0)) else begin
            errors++; $error("FAIL %s active: got %b expected %b", tag, active, (m_state != 0));
        end
        checks++;
        assert (kidx === 3'(m_key)) else begin
            errors++; $error("FAIL %s key_idx: got %0d expected %0d", tag, kidx, m_key);
        end
    endtask

    task automatic run(int n, string tag);
        repeat (n) begin
            @(posedge clk); #1;
            model_edge();
            check_outputs(tag);
        end
        $display("phase %-12s btn=%b oct=%0d en=%b key=%0d active=%b", tag, btn, oct, en, kidx, active);
    endtask

    initial begin
        int seg_len;
        int guard;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        rst_n = 1'b1;

        // Single key, octave 0: 4 high / 4 low, first high 4 edges after press
        en = 1'b1; btn = 8'h01;
        run(30, "key0");
        // Two keys then release key 0: switch to key 1 (3/3)
        btn = 8'h03; run(12, "key0+1");
        btn = 8'h02; run(20, "key1");
        // Release everything: tone sustains 20 cycles then stops
        btn = 8'h00; run(28, "sustain");
        // Octave 1 at press, then octave changed mid-note (no effect)
        oct = 2'd1; btn = 8'h01; run(12, "oct1");
        oct = 2'd3; run(12, "oct_hold");
        // Re-press during sustain with octave 3: clamped divisor of 2
        btn = 8'h00; run(5, "rel");
        btn = 8'h01; run(12, "oct3");
        // Enable drop during a tone
        oct = 2'd0; run(6, "oct3_more");
        en = 1'b0; run(5, "enable_off");
        en = 1'b1; run(12, "enable_on");
        // Same key re-pressed during sustain restarts the note
        btn = 8'h00; run(8, "sus_same");
        btn = 8'h01; run(12, "repress");

        // Asynchronous reset while the output is high
        guard = 0;
        while (exp_p != 1'b1 && guard < 20) begin
            @(posedge clk); #1; model_edge(); check_outputs("pre_rst"); guard++;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        assert (piezo === 1'b0 && active === 1'b0) else begin
            errors++; $error("FAIL async_rst: got piezo=%b active=%b expected 0 0", piezo, active);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("in_reset");
        rst_n = 1'b1;
        run(10, "after_rst");

        // Randomised traffic
        for (int s = 0; s < 60; s++) begin
            case ($urandom_range(0, 4))
                0: btn = '0;
                1: btn = NK'($urandom_range(0, 3));
                2: btn = NK'(1 << $urandom_range(0, NK - 1));
                default: btn = NK'($urandom_range(0, 255));
            endcase
            if ($urandom_range(0, 3) == 0) oct = 2'($urandom_range(0, 3));
            en = ($urandom_range(0, 9) != 0);
            seg_len = $urandom_range(1, 30);
            run(seg_len, "random");
        end
        en = 1'b1; btn = '0;
        run(30, "drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
